// File: rtl/flag_op_scheduler_pkg.sv
// Shared opcodes, FSM state type and the single-bit flag ALU for flag_op_scheduler.
package flag_op_scheduler_pkg;

  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_OR  = 3'd1;
  localparam logic [2:0] OP_NOT = 3'd2;
  localparam logic [2:0] OP_EQ  = 3'd3;
  localparam logic [2:0] OP_MUX = 3'd4;
  localparam logic [2:0] OP_AND = 3'd5;
  localparam logic [2:0] OP_CLR = 3'd6;
  localparam logic [2:0] OP_SET = 3'd7;

  typedef enum logic [1:0] {StIdle, StGrant, StExec} state_e;

  function automatic logic flag_alu(input logic [2:0] op, input logic a, input logic b,
                                    input logic c);
    logic r;
    r = 1'b0;
    case (op)
      OP_NOP:  r = 1'b0;
      OP_OR:   r = a | b;
      OP_NOT:  r = ~a;
      OP_EQ:   r = (a == b);
      OP_MUX:  r = a ? b : c;
      OP_AND:  r = a & b & c;
      OP_CLR:  r = 1'b0;
      OP_SET:  r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/flag_op_scheduler_rr_pick.sv
// Combinational round-robin picker: first set bit of req searching upward from ptr, wrapping.
module rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic            valid
);

  logic [PW-1:0] idx;

  always_comb begin
    gnt   = '0;
    valid = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = PW'((32'(ptr) + k) % NREQ);
      if (!valid && req[idx]) begin
        gnt[idx] = 1'b1;
        valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/flag_op_scheduler.sv
// Round-robin scheduler sharing one flag ALU and flag register between NREQ requesters.
// Define FLAG_OP_SCHED_LOCK_EN to add the LOCK input that pins the pointer on the winner.
module flag_op_scheduler
  import flag_op_scheduler_pkg::*;
#(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned NFLAG = 8,
  parameter int unsigned IW    = 3
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [NREQ-1:0]      REQ,
  input  logic [3*NREQ-1:0]    OP,
  input  logic [IW*NREQ-1:0]   SRC_A,
  input  logic [IW*NREQ-1:0]   SRC_B,
  input  logic [IW*NREQ-1:0]   SRC_C,
  input  logic [IW*NREQ-1:0]   DST,
`ifdef FLAG_OP_SCHED_LOCK_EN
  input  logic [NREQ-1:0]      LOCK,
`endif
  output logic [NREQ-1:0]      GNT,
  output logic [NREQ-1:0]      ACK,
  output logic [NFLAG-1:0]     FLAGS
);

  localparam int unsigned PW = $clog2(NREQ);

  state_e           state_q, state_d;
  logic [NREQ-1:0]  gnt_q, gnt_d, ack_q, ack_d;
  logic [NFLAG-1:0] flags_q, flags_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [2:0]       op_q, op_d;
  logic [IW-1:0]    a_q, a_d, b_q, b_d, c_q, c_d, dst_q, dst_d;

  logic [NREQ-1:0]  pick_req, pick_gnt;
  logic             pick_valid;
  logic [PW-1:0]    sel;
  logic [2:0]       sel_op;
  logic [IW-1:0]    sel_a, sel_b, sel_c, sel_dst;
  logic             sel_req, res;
`ifdef FLAG_OP_SCHED_LOCK_EN
  logic             sel_lock;
`endif

  // Out-of-range indices read as 0.
  function automatic logic rd_flag(input logic [NFLAG-1:0] f, input logic [IW-1:0] idx);
    if (32'(idx) < NFLAG) return f[idx];
    return 1'b0;
  endfunction

  // A requester just acknowledged sits out the pick made in its ACK cycle.
  assign pick_req = REQ & ~ack_q;

  rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_rr_pick (
    .req   (pick_req),
    .ptr   (ptr_q),
    .gnt   (pick_gnt),
    .valid (pick_valid)
  );

  always_comb begin
    sel     = '0;
    sel_op  = '0;
    sel_a   = '0;
    sel_b   = '0;
    sel_c   = '0;
    sel_dst = '0;
`ifdef FLAG_OP_SCHED_LOCK_EN
    sel_lock = 1'b0;
`endif
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt_q[i]) begin
        sel     = PW'(i);
        sel_op  = OP[3*i +: 3];
        sel_a   = SRC_A[IW*i +: IW];
        sel_b   = SRC_B[IW*i +: IW];
        sel_c   = SRC_C[IW*i +: IW];
        sel_dst = DST[IW*i +: IW];
`ifdef FLAG_OP_SCHED_LOCK_EN
        sel_lock = LOCK[i];
`endif
      end
    end
  end

  assign sel_req = |(REQ & gnt_q);
  assign res     = flag_alu(op_q, rd_flag(flags_q, a_q), rd_flag(flags_q, b_q),
                            rd_flag(flags_q, c_q));

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ack_d   = '0;
    flags_d = flags_q;
    ptr_d   = ptr_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    dst_d   = dst_q;
    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          gnt_d   = pick_gnt;
          state_d = StGrant;
        end
      end
      StGrant: begin
        if (sel_req) begin
          op_d    = sel_op;
          a_d     = sel_a;
          b_d     = sel_b;
          c_d     = sel_c;
          dst_d   = sel_dst;
          state_d = StExec;
        end else begin
          gnt_d   = '0;
          state_d = StIdle;
        end
      end
      StExec: begin
        if (op_q != OP_NOP && 32'(dst_q) < NFLAG) flags_d[dst_q] = res;
        gnt_d   = '0;
        ack_d   = gnt_q;
        ptr_d   = PW'((32'(sel) + 1) % NREQ);
`ifdef FLAG_OP_SCHED_LOCK_EN
        if (sel_lock) ptr_d = sel;
`endif
        state_d = StIdle;
      end
      default: begin
        gnt_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
      gnt_q   <= '0;
      ack_q   <= '0;
      flags_q <= '0;
      ptr_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      dst_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      flags_q <= flags_d;
      ptr_q   <= ptr_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      dst_q   <= dst_d;
    end
  end

  assign GNT   = gnt_q;
  assign ACK   = ack_q;
  assign FLAGS = flags_q;

endmodule

// File: tb/tb_flag_op_scheduler.sv
// Self-checking bench for flag_op_scheduler: directed vectors, corner sequences, random vs model.
module tb_flag_op_scheduler;

  localparam int NREQ  = 4;
  localparam int NFLAG = 8;
  localparam int IW    = 3;

  logic                CLK = 1'b0;
  logic                RST;
  logic [NREQ-1:0]     REQ;
  logic [3*NREQ-1:0]   OP;
  logic [IW*NREQ-1:0]  SRC_A, SRC_B, SRC_C, DST;
  logic [NREQ-1:0]     GNT, ACK;
  logic [NFLAG-1:0]    FLAGS;
`ifdef FLAG_OP_SCHED_LOCK_EN
  logic [NREQ-1:0]     LOCK;
`endif

  int checks = 0;
  int errors = 0;

  logic [2:0]    r_op [NREQ];
  logic [IW-1:0] r_a  [NREQ];
  logic [IW-1:0] r_b  [NREQ];
  logic [IW-1:0] r_c  [NREQ];
  logic [IW-1:0] r_d  [NREQ];

  typedef struct {
    int             r;
    logic [2:0]     op;
    logic [IW-1:0]  a, b, c, dst;
    logic [NFLAG-1:0] exp;
  } vec_t;

  vec_t vt[14];

  always #5 CLK = ~CLK;

  flag_op_scheduler #(
    .NREQ  (NREQ),
    .NFLAG (NFLAG),
    .IW    (IW)
  ) dut (
    .CLK   (CLK),
    .RST   (RST),
    .REQ   (REQ),
    .OP    (OP),
    .SRC_A (SRC_A),
    .SRC_B (SRC_B),
    .SRC_C (SRC_C),
    .DST   (DST),
`ifdef FLAG_OP_SCHED_LOCK_EN
    .LOCK  (LOCK),
`endif
    .GNT   (GNT),
    .ACK   (ACK),
    .FLAGS (FLAGS)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic apply_fields();
    for (int i = 0; i < NREQ; i++) begin
      OP[3*i +: 3]     = r_op[i];
      SRC_A[IW*i +: IW] = r_a[i];
      SRC_B[IW*i +: IW] = r_b[i];
      SRC_C[IW*i +: IW] = r_c[i];
      DST[IW*i +: IW]   = r_d[i];
    end
  endtask

  task automatic wait_gnt(output int who);
    who = -1;
    for (int n = 0; n < 20 && who < 0; n++) begin
      step();
      for (int i = 0; i < NREQ; i++) if (GNT[i]) who = i;
    end
    if (who < 0) begin
      checks++;
      errors++;
      $display("FAIL wait_gnt: no grant within 20 cycles");
    end
  endtask

  task automatic wait_ack(output logic [NREQ-1:0] a);
    a = '0;
    for (int n = 0; n < 20 && a == '0; n++) begin
      step();
      a = ACK;
    end
    if (a == '0) begin
      checks++;
      errors++;
      $display("FAIL wait_ack: no ACK within 20 cycles");
    end
  endtask

  // Single isolated op: checks the t+1 grant and t+3 ACK/FLAGS latency.
  task automatic do_op(input vec_t v);
    r_op[v.r] = v.op;
    r_a[v.r]  = v.a;
    r_b[v.r]  = v.b;
    r_c[v.r]  = v.c;
    r_d[v.r]  = v.dst;
    apply_fields();
    REQ = '0;
    REQ[v.r] = 1'b1;
    step();
    check("vec_gnt", 32'(GNT), 32'(4'b0001 << v.r));
    step();
    step();
    check("vec_ack", 32'(ACK), 32'(4'b0001 << v.r));
    check("vec_flags", 32'(FLAGS), 32'(v.exp));
    REQ = '0;
    step();
    check("vec_ack_clear", 32'(ACK), 32'(0));
  endtask

  function automatic int ref_result(input logic [2:0] op, input logic a, input logic b,
                                    input logic c);
    case (op)
      3'd1:    return int'(a || b);
      3'd2:    return int'(!a);
      3'd3:    return int'(a == b);
      3'd4:    return a ? int'(b) : int'(c);
      3'd5:    return int'(a && b && c);
      3'd6:    return 0;
      3'd7:    return 1;
      default: return -1;
    endcase
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int               w;
    int               exp_order[5];
    logic [NREQ-1:0]  a;
    logic [NFLAG-1:0] m_flags;
    int               m_ptr, m_owner, m_age;
    bit               m_busy;
    logic [NREQ-1:0]  m_ack_last, pend, applied, cand, exp_gnt, exp_ack;
    int               rv;

    vt[0]  = '{2, 3'd7, 3'd0, 3'd0, 3'd0, 3'd5, 8'h20};
    vt[1]  = '{0, 3'd7, 3'd0, 3'd0, 3'd0, 3'd0, 8'h21};
    vt[2]  = '{1, 3'd7, 3'd0, 3'd0, 3'd0, 3'd1, 8'h23};
    vt[3]  = '{3, 3'd6, 3'd0, 3'd0, 3'd0, 3'd5, 8'h03};
    vt[4]  = '{0, 3'd4, 3'd0, 3'd2, 3'd1, 3'd3, 8'h03};
    vt[5]  = '{1, 3'd2, 3'd3, 3'd0, 3'd0, 3'd3, 8'h0B};
    vt[6]  = '{2, 3'd1, 3'd3, 3'd2, 3'd0, 3'd7, 8'h8B};
    vt[7]  = '{3, 3'd3, 3'd2, 3'd4, 3'd0, 3'd2, 8'h8F};
    vt[8]  = '{0, 3'd5, 3'd0, 3'd1, 3'd3, 3'd6, 8'hCF};
    vt[9]  = '{1, 3'd5, 3'd0, 3'd4, 3'd1, 3'd0, 8'hCE};
    vt[10] = '{2, 3'd0, 3'd0, 3'd0, 3'd0, 3'd7, 8'hCE};
    vt[11] = '{3, 3'd2, 3'd7, 3'd0, 3'd0, 3'd7, 8'h4E};
    vt[12] = '{0, 3'd3, 3'd6, 3'd7, 3'd0, 3'd1, 8'h4C};
    vt[13] = '{1, 3'd1, 3'd4, 3'd5, 3'd0, 3'd3, 8'h44};

    for (int i = 0; i < NREQ; i++) begin
      r_op[i] = 3'd0;
      r_a[i]  = '0;
      r_b[i]  = '0;
      r_c[i]  = '0;
      r_d[i]  = '0;
    end
    apply_fields();
`ifdef FLAG_OP_SCHED_LOCK_EN
    LOCK = '0;
`endif

    // Reset with all requests high, then fairness with drops after ACK
    REQ = '1;
    RST = 1'b1;
    for (int n = 0; n < 2; n++) begin
      step();
      check("rst_flags", 32'(FLAGS), 32'(0));
      check("rst_gnt", 32'(GNT), 32'(0));
      check("rst_ack", 32'(ACK), 32'(0));
    end
    RST = 1'b0;
    exp_order = '{0, 1, 2, 3, 0};
    for (int k = 0; k < 5; k++) begin
      wait_gnt(w);
      check("fair_gnt", 32'(w), 32'(exp_order[k]));
      if (k == 1) REQ[0] = 1'b1;
      wait_ack(a);
      check("fair_ack", 32'(a), 32'(4'b0001 << exp_order[k]));
      REQ[exp_order[k]] = 1'b0;
    end
    step();

    // Directed datapath vectors
    for (int i = 0; i < 14; i++) do_op(vt[i]);

    // Abort: REQ[1] dropped while granted
    r_op[1] = 3'd7;
    r_d[1]  = 3'd0;
    apply_fields();
    REQ = 4'b0010;
    step();
    check("abort_gnt", 32'(GNT), 32'(4'b0010));
    REQ = '0;
    step();
    check("abort_gnt_clear", 32'(GNT), 32'(0));
    for (int n = 0; n < 3; n++) begin
      step();
      check("abort_no_ack", 32'(ACK), 32'(0));
      check("abort_flags", 32'(FLAGS), 32'(8'h44));
    end

    // Reset arriving during EXEC
    r_op[2] = 3'd7;
    r_d[2]  = 3'd0;
    apply_fields();
    REQ = 4'b0100;
    step();
    step();
    check("rstexec_gnt", 32'(GNT), 32'(4'b0100));
    RST = 1'b1;
    step();
    check("rstexec_flags", 32'(FLAGS), 32'(0));
    check("rstexec_ack", 32'(ACK), 32'(0));
    check("rstexec_gnt_clear", 32'(GNT), 32'(0));
    RST = 1'b0;
    REQ = '0;
    step();
    check("rstexec_ack_after", 32'(ACK), 32'(0));

`ifdef FLAG_OP_SCHED_LOCK_EN
    for (int i = 0; i < NREQ; i++) r_op[i] = 3'd0;
    apply_fields();
    REQ  = 4'b0011;
    LOCK = 4'b0001;
    exp_order = '{0, 1, 0, 1, 0};
    for (int k = 0; k < 4; k++) begin
      wait_gnt(w);
      check("lock_gnt", 32'(w), 32'(exp_order[k]));
      wait_ack(a);
    end
    LOCK = '0;
    REQ  = 4'b0111;
    exp_order = '{2, 0, 1, 0, 0};
    for (int k = 0; k < 3; k++) begin
      wait_gnt(w);
      check("unlock_gnt", 32'(w), 32'(exp_order[k]));
      wait_ack(a);
    end
    REQ = '0;
    step();
    step();
`endif

    // Random traffic against a transaction-level model
    RST = 1'b1;
    REQ = '0;
    step();
    step();
    RST = 1'b0;
    m_flags    = '0;
    m_ptr      = 0;
    m_owner    = 0;
    m_age      = 0;
    m_busy     = 1'b0;
    m_ack_last = '0;
    pend       = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && $urandom_range(3) == 0) begin
          pend[i] = 1'b1;
          r_op[i] = 3'($urandom_range(7));
          r_a[i]  = IW'($urandom_range(NFLAG - 1));
          r_b[i]  = IW'($urandom_range(NFLAG - 1));
          r_c[i]  = IW'($urandom_range(NFLAG - 1));
          r_d[i]  = IW'($urandom_range(NFLAG - 1));
        end
      end
      apply_fields();
      REQ     = pend;
      applied = pend;
      step();

      exp_gnt = '0;
      exp_ack = '0;
      if (!m_busy) begin
        cand = applied & ~m_ack_last;
        for (int k = 0; k < NREQ; k++) begin
          if (!m_busy && cand[(m_ptr + k) % NREQ]) begin
            m_busy  = 1'b1;
            m_owner = (m_ptr + k) % NREQ;
            m_age   = 1;
          end
        end
        if (m_busy) exp_gnt[m_owner] = 1'b1;
      end else if (m_age == 1) begin
        m_age = 2;
        exp_gnt[m_owner] = 1'b1;
      end else begin
        exp_ack[m_owner] = 1'b1;
        rv = ref_result(r_op[m_owner], m_flags[r_a[m_owner]], m_flags[r_b[m_owner]],
                        m_flags[r_c[m_owner]]);
        if (rv >= 0) m_flags[r_d[m_owner]] = rv[0];
        m_ptr  = (m_owner + 1) % NREQ;
        m_busy = 1'b0;
      end
      m_ack_last = exp_ack;

      check("rand_gnt", 32'(GNT), 32'(exp_gnt));
      check("rand_ack", 32'(ACK), 32'(exp_ack));
      check("rand_flags", 32'(FLAGS), 32'(m_flags));
      if (exp_ack != '0) pend[m_owner] = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
